// File: rtl/rs_pipeline_credit_ctrl.sv
// Credit-based flow controller for a fixed-latency relay-station pipeline.
// Upstream ready is gated by credits so the tail FIFO can never overflow.
module rs_pipeline_credit_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  pp_in_valid,
   output logic [DATA_WIDTH-1:0] pp_in_data,
   input  logic                  pp_out_valid,
   input  logic [DATA_WIDTH-1:0] pp_out_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_W-1:0]      credits,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  err_overflow,
   output logic                  err_credit
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int DC_W  = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {ST_DRAIN, ST_RUN} state_t;

   state_t                state, state_nxt;
   logic [DC_W-1:0]       drain_cnt;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic                  accept, pop, push_req, push, full;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_DRAIN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_DRAIN && drain_cnt == DC_W'(1)) state_nxt = ST_RUN;
   end

   always_comb begin
      s_ready = (state == ST_RUN) && (credits != '0);
   end

   // Drain flushes whatever the unreset pipeline still holds.
   always_ff @(posedge clk) begin
      if (reset)
         drain_cnt <= DC_W'(LATENCY);
      else if (state == ST_DRAIN && drain_cnt != '0)
         drain_cnt <= drain_cnt - DC_W'(1);
   end

   assign accept      = s_valid && s_ready;
   assign pp_in_valid = accept;
   assign pp_in_data  = s_data;

   assign full     = (fifo_count == DEPTH_C);
   assign m_valid  = (fifo_count != '0);
   assign m_data   = mem[rd_ptr];
   assign pop      = m_valid && m_ready;
   assign push_req = pp_out_valid && (state == ST_RUN);
   // A push into a full FIFO is legal only when a pop frees the slot this cycle.
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pp_out_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         credits      <= DEPTH_C;
         err_credit   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         unique case ({accept, pop})
            2'b10: begin
               if (credits == '0) err_credit <= 1'b1;
               else               credits    <= credits - CNT_W'(1);
            end
            2'b01: begin
               if (credits == DEPTH_C) err_credit <= 1'b1;
               else                    credits    <= credits + CNT_W'(1);
            end
            default: ;
         endcase
         if (push_req && full && !pop) err_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rs_pipeline_credit_ctrl.sv
// Bench: fixed-latency pipeline model plus a queue-based reference of the
// credit/FIFO rules, compared every cycle on the falling edge.
module tb_rs_pipeline_credit_ctrl;

   localparam int L  = 8;
   localparam int D  = 16;
   localparam int DW = 32;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset, s_valid, s_ready, pp_in_valid, pp_out_valid;
   logic          m_valid, m_ready, err_overflow, err_credit;
   logic [DW-1:0] s_data, pp_in_data, pp_out_data, m_data;
   logic [CW-1:0] credits, fifo_count;

   always #5 clk = ~clk;

   rs_pipeline_credit_ctrl #(.DATA_WIDTH(DW), .LATENCY(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .pp_in_valid(pp_in_valid), .pp_in_data(pp_in_data),
      .pp_out_valid(pp_out_valid), .pp_out_data(pp_out_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .credits(credits), .fifo_count(fifo_count),
      .err_overflow(err_overflow), .err_credit(err_credit)
   );

   // External relay-station pipeline; inj forces stray output beats.
   logic [L-1:0]  pv = '0;
   logic [DW-1:0] pd [L];
   logic          inj = 1'b0;
   logic [DW-1:0] inj_d = '0;
   assign pp_out_valid = pv[L-1] | inj;
   assign pp_out_data  = inj ? inj_d : pd[L-1];

   always @(posedge clk) begin
      pv    <= {pv[L-2:0], pp_in_valid};
      pd[0] <= pp_in_data;
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
   end

   // Reference model
   logic [DW-1:0] mq[$];
   int mcred = D, mdrain = L;
   bit meo = 0, mec = 0, mon = 0;

   always @(posedge clk) begin : mdl
      bit sr, acc, pp, psh, fl;
      if (reset) begin
         mq.delete(); mcred = D; mdrain = L; meo = 0; mec = 0; mon = 1;
      end else if (mon) begin
         sr  = (mdrain == 0) && (mcred != 0);
         acc = s_valid && sr;
         fl  = (mq.size() == D);
         pp  = (mq.size() != 0) && m_ready;
         psh = pp_out_valid && (mdrain == 0);
         if (pp) void'(mq.pop_front());
         if (psh) begin
            if (fl && !pp) meo = 1;
            else           mq.push_back(pp_out_data);
         end
         mcred = mcred - int'(acc) + int'(pp);
         if (mcred > D) begin mcred = D; mec = 1; end
         if (mdrain > 0) mdrain--;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_all();
      bit sr;
      sr = (mdrain == 0) && (mcred != 0);
      chk("s_ready", 64'(s_ready), 64'(sr));
      chk("pp_in_valid", 64'(pp_in_valid), 64'(s_valid && sr));
      if (s_valid && sr) chk("pp_in_data", 64'(pp_in_data), 64'(s_data));
      chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("m_data", 64'(m_data), 64'(mq[0]));
      chk("credits", 64'(credits), 64'(mcred));
      chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
      chk("err_overflow", 64'(err_overflow), 64'(meo));
      chk("err_credit", 64'(err_credit), 64'(mec));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (mon) check_all();
   endtask

   initial begin
      int n, k, stalls, mincred;
      reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      repeat (2) step();

      // Drain: s_valid held high, stray pipeline beats must be ignored.
      reset = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5_0001;
      n = 0;
      while (!s_ready && n < 50) begin
         inj = 1'($urandom_range(0, 1)); inj_d = $urandom;
         step(); n++;
      end
      inj = 1'b0;
      chk("drain_len", 64'(n), 64'(L));
      chk("drain_fifo_count", 64'(fifo_count), 64'(0));

      // Single item latency
      m_ready = 1'b1;
      step(); s_valid = 1'b0;
      n = 1;
      while (!m_valid && n < 50) begin step(); n++; end
      chk("single_latency", 64'(n), 64'(L + 1));
      chk("single_data", 64'(m_data), 64'(32'hA5A5_0001));
      repeat (3) step();
      chk("single_credit_back", 64'(credits), 64'(D));

      // Full-rate stream
      k = 0; stalls = 0; mincred = D;
      for (int c = 0; c < 400 && k < 100; c++) begin
         s_valid = 1'b1; s_data = 32'h1000 + k;
         if (!s_ready) stalls++;
         if (int'(credits) < mincred) mincred = int'(credits);
         step();
         if (pv[0]) k++;
      end
      s_valid = 1'b0;
      chk("stream_count", 64'(k), 64'(100));
      chk("stream_stalls", 64'(stalls), 64'(0));
      chk("stream_min_credit", 64'(mincred), 64'(D - L - 1));
      repeat (20) step();

      // Fill with downstream stalled
      m_ready = 1'b0; k = 0;
      for (int c = 0; c < 40; c++) begin
         s_valid = 1'b1; s_data = 32'h2000 + k;
         if (s_ready) k++;
         step();
      end
      chk("fill_accepts", 64'(k), 64'(D));
      chk("fill_count", 64'(fifo_count), 64'(D));
      chk("fill_credits", 64'(credits), 64'(0));

      // Stray beat into a full FIFO is dropped and flagged
      s_valid = 1'b0; inj = 1'b1; inj_d = 32'hDEAD_BEEF;
      step(); inj = 1'b0;
      chk("ovf_flag", 64'(err_overflow), 64'(1));
      chk("ovf_head", 64'(m_data), 64'(32'h2000));
      chk("ovf_count", 64'(fifo_count), 64'(D));

      // Release: ready returns after first pop; long run wraps pointers
      m_ready = 1'b1; s_valid = 1'b1;
      step();
      chk("release_ready", 64'(s_ready), 64'(1));
      for (int c = 0; c < 60; c++) begin
         s_data = 32'h2000 + k;
         if (s_ready) k++;
         step();
      end
      s_valid = 1'b0;
      repeat (20) step();

      // Random traffic with a mid-stream reset
      for (int c = 0; c < 400; c++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = $urandom;
         m_ready = ($urandom_range(0, 3) != 0);
         reset   = (c == 200);
         inj     = (mdrain > 0) && ($urandom_range(0, 1) != 0);
         inj_d   = $urandom;
         step();
         if (c == 200) begin
            chk("rst_m_valid", 64'(m_valid), 64'(0));
            chk("rst_err_overflow", 64'(err_overflow), 64'(0));
            chk("rst_s_ready", 64'(s_ready), 64'(0));
         end
      end
      reset = 1'b0; inj = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
